// File: rtl/cm0_dap_cdc_rx_handshake.sv
// Receive end of the DAP 4-phase REQ/ACK crossing: synchronises REQ, captures the data bus into a one-entry buffer.
// Optional even-parity check on the captured word is enabled by defining CM0_DAP_CDC_RX_PARITY_EN.
module cm0_dap_cdc_rx_handshake #(
    parameter int PRESENT     = 1,
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             REQASYNC,
    input  logic [WIDTH-1:0] DATAASYNC,
`ifdef CM0_DAP_CDC_RX_PARITY_EN
    input  logic             PARASYNC,
    output logic             RPARERR,
`endif
    output logic             ACKOUT,
    output logic [WIDTH-1:0] RDATA,
    output logic             RVALID,
    input  logic             RREADY
);

    typedef enum logic {
        IDLE   = 1'b0,
        WAITLO = 1'b1
    } state_t;

    generate
        if (PRESENT != 0) begin : g_rx
            logic [SYNC_STAGES-1:0] sync_reg;
            logic                   req_s;
            state_t                 state_reg, state_next;
            logic                   ack_reg, ack_next;
            logic                   rvalid_reg, rvalid_next;
            logic [WIDTH-1:0]       rdata_reg;
            logic                   capture;
            logic                   buf_free;

            always_ff @(posedge CLK or posedge RESET) begin
                if (RESET) begin
                    sync_reg <= '0;
                end else begin
                    sync_reg <= {sync_reg[SYNC_STAGES-2:0], REQASYNC};
                end
            end

            assign req_s    = sync_reg[SYNC_STAGES-1];
            assign buf_free = !rvalid_reg || RREADY;

            always_comb begin
                state_next = state_reg;
                ack_next   = ack_reg;
                capture    = 1'b0;
                case (state_reg)
                    IDLE: begin
                        ack_next = 1'b0;
                        if (req_s && buf_free) begin
                            capture    = 1'b1;
                            ack_next   = 1'b1;
                            state_next = WAITLO;
                        end
                    end
                    WAITLO: begin
                        ack_next = 1'b1;
                        if (!req_s) begin
                            ack_next   = 1'b0;
                            state_next = IDLE;
                        end
                    end
                    default: begin
                        ack_next   = 1'b0;
                        state_next = IDLE;
                    end
                endcase
            end

            // A capture on the same edge as a consume keeps RVALID high (no bubble).
            assign rvalid_next = capture || (rvalid_reg && !RREADY);

            always_ff @(posedge CLK or posedge RESET) begin
                if (RESET) begin
                    state_reg  <= IDLE;
                    ack_reg    <= 1'b0;
                    rvalid_reg <= 1'b0;
                    rdata_reg  <= '0;
                end else begin
                    state_reg  <= state_next;
                    ack_reg    <= ack_next;
                    rvalid_reg <= rvalid_next;
                    if (capture) begin
                        rdata_reg <= DATAASYNC;
                    end
                end
            end

            assign ACKOUT = ack_reg;
            assign RVALID = rvalid_reg;
            assign RDATA  = rdata_reg;

`ifdef CM0_DAP_CDC_RX_PARITY_EN
            logic parerr_reg;

            always_ff @(posedge CLK or posedge RESET) begin
                if (RESET) begin
                    parerr_reg <= 1'b0;
                end else if (capture) begin
                    parerr_reg <= ^{DATAASYNC, PARASYNC};
                end
            end

            assign RPARERR = parerr_reg;
`endif
        end else begin : g_absent
            logic unused_inputs;

            assign unused_inputs = ^{CLK, RESET, REQASYNC, DATAASYNC, RREADY};
            assign ACKOUT        = 1'b0;
            assign RVALID        = 1'b0;
            assign RDATA         = '0;
`ifdef CM0_DAP_CDC_RX_PARITY_EN
            logic unused_parity;

            assign unused_parity = PARASYNC;
            assign RPARERR       = 1'b0;
`endif
        end
    endgenerate

endmodule
